// File: rtl/serial_add_sequencer.sv
// Bit-serial adder/subtractor controller.
// A single 1-bit full-adder cell is reused for WIDTH cycles, consuming the
// operands LSB-first. Subtraction runs as A + ~B + 1 through the same cell.
// Handshake: start is accepted only in IDLE, busy is high while bits are
// processed, and done pulses for one cycle with registered result flags.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Plain combinational 1-bit full adder
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (cin & (a ^ b));
    end

endmodule

module serial_add_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter value seen on the final RUN edge
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Registered state
    logic [1:0]       state_reg,     state_next;
    logic [WIDTH-1:0] a_sh_reg,      a_sh_next;
    logic [WIDTH-1:0] b_sh_reg,      b_sh_next;
    logic [WIDTH-1:0] res_sh_reg,    res_sh_next;
    logic             carry_reg,     carry_next;
    logic [CNT_W-1:0] cnt_reg,       cnt_next;
    logic             a_msb_reg,     a_msb_next;
    logic             b_msb_reg,     b_msb_next;
    logic [WIDTH-1:0] result_reg,    result_next;
    logic             carry_out_reg, carry_out_next;
    logic             overflow_reg,  overflow_next;
    logic             zero_reg,      zero_next;

    // Datapath helpers
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] res_shifted;
    logic             fa_sum;
    logic             fa_cout;

    // Effective B operand: each bit inverted when subtracting
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_b_eff
            assign b_eff[gi] = b[gi] ^ op_sub;
        end
    endgenerate

    // The one shared full-adder cell, fed from the shift register LSBs
    full_adder u_fa (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // New sum bit enters at the top so the LSB ends up at bit 0 after WIDTH shifts
    assign res_shifted = {fa_sum, res_sh_reg[WIDTH-1:1]};

    // Next-state and datapath control
    always_comb begin
        state_next     = state_reg;
        a_sh_next      = a_sh_reg;
        b_sh_next      = b_sh_reg;
        res_sh_next    = res_sh_reg;
        carry_next     = carry_reg;
        cnt_next       = cnt_reg;
        a_msb_next     = a_msb_reg;
        b_msb_next     = b_msb_reg;
        result_next    = result_reg;
        carry_out_next = carry_out_reg;
        overflow_next  = overflow_reg;
        zero_next      = zero_reg;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    a_sh_next  = a;
                    b_sh_next  = b_eff;
                    carry_next = op_sub;
                    cnt_next   = '0;
                    a_msb_next = a[WIDTH-1];
                    b_msb_next = b_eff[WIDTH-1];
                    state_next = S_RUN;
                end
            end

            S_RUN: begin
                res_sh_next = res_shifted;
                a_sh_next   = a_sh_reg >> 1;
                b_sh_next   = b_sh_reg >> 1;
                carry_next  = fa_cout;
                cnt_next    = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_CNT) begin
                    // Final bit: publish the flags on the same edge that enters DONE
                    state_next     = S_DONE;
                    result_next    = res_shifted;
                    carry_out_next = fa_cout;
                    overflow_next  = (a_msb_reg == b_msb_reg) && (fa_sum != a_msb_reg);
                    zero_next      = (res_shifted == '0);
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            res_sh_reg    <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            a_msb_reg     <= 1'b0;
            b_msb_reg     <= 1'b0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            a_sh_reg      <= a_sh_next;
            b_sh_reg      <= b_sh_next;
            res_sh_reg    <= res_sh_next;
            carry_reg     <= carry_next;
            cnt_reg       <= cnt_next;
            a_msb_reg     <= a_msb_next;
            b_msb_reg     <= b_msb_next;
            result_reg    <= result_next;
            carry_out_reg <= carry_out_next;
            overflow_reg  <= overflow_next;
            zero_reg      <= zero_next;
        end
    end

    // Handshake outputs decode straight from the state register
    assign busy      = (state_reg == S_RUN);
    assign done      = (state_reg == S_DONE);
    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed testbench for serial_add_sequencer at WIDTH=8.
module tb_serial_add_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    int total = 0;
    int bad   = 0;

    serial_add_sequencer #(.WIDTH(W), .CNT_W(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done; counts busy cycles and flags busy/done overlap.
    task automatic wait_done(output int nbusy, output int lat, output logic overlap);
        nbusy   = 0;
        lat     = 0;
        overlap = 1'b0;
        while (!done && lat < 30) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            lat++;
            if (busy && done) overlap = 1'b1;
        end
    endtask

    // One full operation: accept, scramble inputs, wait, check flags and return to IDLE.
    task automatic do_op(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic isub, input logic [W-1:0] er, input logic ec,
                         input logic eov, input logic ez);
        int   nb;
        int   lat;
        logic ovl;
        a = ia; b = ib; op_sub = isub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 8'hA5; b = 8'h5A; op_sub = ~isub;
        wait_done(nb, lat, ovl);
        check({tag, "_done"},    done, 1);
        check({tag, "_latency"}, lat, W);
        check({tag, "_busycyc"}, nb, W);
        check({tag, "_overlap"}, ovl, 0);
        check({tag, "_result"},  result, er);
        check({tag, "_carry"},   carry_out, ec);
        check({tag, "_ovf"},     overflow, eov);
        check({tag, "_zero"},    zero, ez);
        $display("op %s a=%0h b=%0h sub=%0b result=%0h c=%0b v=%0b z=%0b", tag, ia, ib, isub,
                 result, carry_out, overflow, zero);
        @(posedge clk); #1;
        check({tag, "_pulse"}, done, 0);
        check({tag, "_idle"},  busy, 0);
    endtask

    initial begin
        int   nb;
        int   lat;
        int   ndone;
        logic ovl;
        logic [W-1:0] seen;

        reset = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry_out, 0);
        check("rst_ovf", overflow, 0);
        check("rst_zero", zero, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op("add_5_3",   8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("hold_result", result, 8'h08);
        do_op("add_ff_1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        do_op("sub_5_3",   8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0);
        do_op("sub_3_5",   8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        do_op("add_7f_1",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        do_op("sub_80_1",  8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

        // Start pulses during RUN must be ignored
        a = 8'h10; b = 8'h20; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        seen  = '0;
        for (int i = 0; i < 14; i++) begin
            if (i == 2 || i == 7) begin
                start = 1'b1; a = 8'h01; b = 8'h01; op_sub = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                seen = result;
            end
        end
        start = 1'b0;
        check("ign_ndone", ndone, 1);
        check("ign_result", seen, 8'h30);
        check("ign_idle", busy, 0);
        $display("op ignore_start dones=%0d result=%0h", ndone, seen);

        // Reset at RUN cycle 4 discards the operation
        a = 8'h11; b = 8'h22; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_result", result, 0);
        check("mrst_carry", carry_out, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        check("mrst_quiet", ndone, 0);
        $display("op mid_run_reset result=%0h", result);
        do_op("after_rst", 8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);

        // Continuous start: re-accepted on the first IDLE cycle after DONE
        a = 8'h02; b = 8'h03; op_sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        wait_done(nb, lat, ovl);
        check("cont1_done", done, 1);
        check("cont1_result", result, 8'h05);
        @(posedge clk); #1;
        check("cont_idle", busy, 0);
        @(posedge clk); #1;
        check("cont_reaccept", busy, 1);
        start = 1'b0;
        wait_done(nb, lat, ovl);
        check("cont2_done", done, 1);
        check("cont2_busycyc", nb, W);
        check("cont2_result", result, 8'h05);
        $display("op continuous_start result=%0h", result);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
